// File: rtl/id_ex_if.sv
// ID/EX pipeline-register bus: decoded ID fields in, registered EX fields out,
// plus the flush/hold controls and the stall/bubble status back to the front end.
interface id_ex_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic          id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst;
  logic [1:0]    id_alu_op;
  logic          id_uses_rs, id_uses_rt;
  logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc4;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          flush, hold;

  logic          stall_o;
  logic          ex_valid;
  logic          ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst;
  logic [1:0]    ex_alu_op;
  logic [5:0]    ex_func;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic [15:0]   bubble_cnt;

  modport master (
    output id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src,
           id_reg_dst, id_alu_op, id_uses_rs, id_uses_rt, id_rd1, id_rd2, id_imm, id_pc4,
           id_rs, id_rt, id_rd, flush, hold,
    input  stall_o, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_alu_src, ex_reg_dst, ex_alu_op, ex_func, ex_rd1, ex_rd2, ex_imm, ex_pc4,
           ex_rs, ex_rt, ex_rd, bubble_cnt
  );

  modport slave (
    input  id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src,
           id_reg_dst, id_alu_op, id_uses_rs, id_uses_rt, id_rd1, id_rd2, id_imm, id_pc4,
           id_rs, id_rt, id_rd, flush, hold,
    output stall_o, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_alu_src, ex_reg_dst, ex_alu_op, ex_func, ex_rd1, ex_rd2, ex_imm, ex_pc4,
           ex_rs, ex_rt, ex_rd, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage for the 5-stage MIPS core. Registers the decoded
// instruction into EX, detects load-use hazards against the load sitting in
// EX, inserts bubbles on hazard or branch flush, and freezes on downstream hold.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic   clk,
  input  logic   rst,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic          vld;
    logic          reg_write;
    logic          mem_to_reg;
    logic          mem_read;
    logic          mem_write;
    logic          alu_src;
    logic          reg_dst;
    logic [1:0]    alu_op;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
  } ex_t;

  ex_t         id_p0;
  ex_t         ex_p1;
  logic [15:0] bubble_cnt_p1;
  logic        lu;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- stage p0: gather the ID-side fields into one record
  always_comb begin
    id_p0            = '0;
    id_p0.vld        = bus.id_valid;
    id_p0.reg_write  = bus.id_reg_write;
    id_p0.mem_to_reg = bus.id_mem_to_reg;
    id_p0.mem_read   = bus.id_mem_read;
    id_p0.mem_write  = bus.id_mem_write;
    id_p0.alu_src    = bus.id_alu_src;
    id_p0.reg_dst    = bus.id_reg_dst;
    id_p0.alu_op     = bus.id_alu_op;
    id_p0.rd1        = bus.id_rd1;
    id_p0.rd2        = bus.id_rd2;
    id_p0.imm        = bus.id_imm;
    id_p0.pc4        = bus.id_pc4;
    id_p0.rs         = bus.id_rs;
    id_p0.rt         = bus.id_rt;
    id_p0.rd         = bus.id_rd;
  end

  // Load in EX whose destination is read by the ID instruction; $zero never hazards
  always_comb begin
    lu = ex_p1.vld & ex_p1.mem_read & (ex_p1.rt != '0) & bus.id_valid &
         ((bus.id_uses_rs & (bus.id_rs == ex_p1.rt)) |
          (bus.id_uses_rt & (bus.id_rt == ex_p1.rt)));
  end

  // A flush kills the ID instruction anyway, so a hazard on it needs no stall
  assign bus.stall_o = ~rst & (bus.hold | (lu & ~bus.flush));

  // ---- stage p1: EX register; priority rst > flush > hold > load-use bubble > load
  always_ff @(posedge clk) begin
    if (rst)            ex_p1 <= '0;
    else if (bus.flush) ex_p1 <= '0;
    else if (!bus.hold) ex_p1 <= lu ? '0 : id_p0;
  end

  // Count only bubbles actually inserted for load-use, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst)                               bubble_cnt_p1 <= '0;
    else if (!bus.flush && !bus.hold && lu) bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
  end

  assign bus.ex_valid      = ex_p1.vld;
  assign bus.ex_reg_write  = ex_p1.reg_write;
  assign bus.ex_mem_to_reg = ex_p1.mem_to_reg;
  assign bus.ex_mem_read   = ex_p1.mem_read;
  assign bus.ex_mem_write  = ex_p1.mem_write;
  assign bus.ex_alu_src    = ex_p1.alu_src;
  assign bus.ex_reg_dst    = ex_p1.reg_dst;
  assign bus.ex_alu_op     = ex_p1.alu_op;
  assign bus.ex_func       = ex_p1.imm[5:0];
  assign bus.ex_rd1        = ex_p1.rd1;
  assign bus.ex_rd2        = ex_p1.rd2;
  assign bus.ex_imm        = ex_p1.imm;
  assign bus.ex_pc4        = ex_p1.pc4;
  assign bus.ex_rs         = ex_p1.rs;
  assign bus.ex_rt         = ex_p1.rt;
  assign bus.ex_rd         = ex_p1.rd;
  assign bus.bubble_cnt    = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/hold/saturation scenarios plus a
// randomized phase, all compared against a rule-level model of the EX register.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_if #(.DW(32), .RW(5)) bus ();

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected EX contents; ctl = {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst}
  typedef struct packed {
    logic        valid;
    logic [5:0]  ctl;
    logic [1:0]  op;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rs, rt, rd;
  } m_t;

  m_t          m;
  logic [15:0] m_cnt;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic        last_stall;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_lu();
    return m.valid && m.ctl[3] && (m.rt != 5'd0) && bus.id_valid &&
           ((bus.id_uses_rs && bus.id_rs == m.rt) || (bus.id_uses_rt && bus.id_rt == m.rt));
  endfunction

  function automatic logic exp_stall();
    return !rst && (bus.hold || (model_lu() && !bus.flush));
  endfunction

  function automatic logic [255:0] obs_vec();
    return {82'd0, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_read,
            bus.ex_mem_write, bus.ex_alu_src, bus.ex_reg_dst, bus.ex_alu_op,
            bus.ex_rd1, bus.ex_rd2, bus.ex_imm, bus.ex_pc4, bus.ex_rs, bus.ex_rt, bus.ex_rd,
            bus.ex_func, bus.bubble_cnt};
  endfunction

  function automatic logic [255:0] exp_vec();
    return {82'd0, m, m.imm[5:0], m_cnt};
  endfunction

  // Apply one clock edge to the model using the inputs currently presented
  task automatic model_edge();
    m_t nxt;
    nxt = m;
    if (rst) begin
      nxt   = '0;
      m_cnt = 16'd0;
    end else if (bus.flush) begin
      nxt = '0;
    end else if (bus.hold) begin
      nxt = m;
    end else if (model_lu()) begin
      nxt   = '0;
      m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    end else begin
      nxt.valid = bus.id_valid;
      nxt.ctl   = {bus.id_reg_write, bus.id_mem_to_reg, bus.id_mem_read,
                   bus.id_mem_write, bus.id_alu_src, bus.id_reg_dst};
      nxt.op    = bus.id_alu_op;
      nxt.rd1   = bus.id_rd1;
      nxt.rd2   = bus.id_rd2;
      nxt.imm   = bus.id_imm;
      nxt.pc4   = bus.id_pc4;
      nxt.rs    = bus.id_rs;
      nxt.rt    = bus.id_rt;
      nxt.rd    = bus.id_rd;
    end
    m = nxt;
  endtask

  // Inputs are already applied; check stall before the edge, full EX state after it
  task automatic step(input string tag);
    #2;
    last_stall = bus.stall_o;
    chk({tag, "/stall"}, {255'd0, bus.stall_o}, {255'd0, exp_stall()});
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "/ex"}, obs_vec(), exp_vec());
  endtask

  task automatic set_id(input logic v, input logic [5:0] ctl, input logic [1:0] op,
                        input logic urs, input logic urt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] pc4);
    bus.id_valid      = v;
    bus.id_reg_write  = ctl[5];
    bus.id_mem_to_reg = ctl[4];
    bus.id_mem_read   = ctl[3];
    bus.id_mem_write  = ctl[2];
    bus.id_alu_src    = ctl[1];
    bus.id_reg_dst    = ctl[0];
    bus.id_alu_op     = op;
    bus.id_uses_rs    = urs;
    bus.id_uses_rt    = urt;
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.id_rd         = rd;
    bus.id_rd1        = rd1;
    bus.id_rd2        = rd2;
    bus.id_imm        = imm;
    bus.id_pc4        = pc4;
  endtask

  task automatic rand_id();
    set_id(1'($urandom_range(3) != 0), 6'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom),
           5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
           $urandom, $urandom, $urandom, $urandom);
  endtask

  // lw rt, 4(rs): reg_write, mem_to_reg, mem_read, alu_src
  task automatic id_lw(input logic [4:0] rs, input logic [4:0] rt);
    set_id(1'b1, 6'b111010, 2'b00, 1'b1, 1'b0, rs, rt, 5'd0,
           32'h0000_1000, 32'h0, 32'h0000_0004, 32'h0040_0010);
  endtask

  // add $9,$8,$10 : funct 100000, rd=9 encoded in imm[15:11]
  task automatic id_add();
    set_id(1'b1, 6'b100001, 2'b10, 1'b1, 1'b1, 5'd8, 5'd10, 5'd9,
           32'h0000_0011, 32'h0000_0022, 32'h0000_4820, 32'h0040_0014);
  endtask

  initial begin
    #1_000_000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m          = '0;
    m_cnt      = 16'd0;
    last_stall = 1'b0;
    rst        = 1'b1;
    bus.flush  = 1'b0;
    bus.hold   = 1'b0;

    // 1: reset for two cycles with random ID contents
    rand_id();
    step("reset0");
    rand_id();
    step("reset1");
    chk("reset_valid", {255'd0, bus.ex_valid}, 256'd0);
    chk("reset_cnt", {240'd0, bus.bubble_cnt}, 256'd0);
    rst = 1'b0;

    // 2: lw $8 in EX, add reading $8 in ID -> one bubble, then add loads
    id_lw(5'd29, 5'd8);
    step("lu_load");
    id_add();
    step("lu_bubble");
    chk("lu_stall", {255'd0, last_stall}, {255'd0, 1'b1});
    chk("lu_bubble_valid", {255'd0, bus.ex_valid}, 256'd0);
    chk("lu_bubble_memrd", {255'd0, bus.ex_mem_read}, 256'd0);
    chk("lu_cnt1", {240'd0, bus.bubble_cnt}, 256'd1);
    step("lu_resume");
    chk("lu_resume_stall", {255'd0, last_stall}, 256'd0);
    chk("lu_resume_rs", {251'd0, bus.ex_rs}, 256'd8);
    chk("lu_resume_func", {250'd0, bus.ex_func}, {250'd0, 6'b100000});
    chk("lu_resume_op", {254'd0, bus.ex_alu_op}, {254'd0, 2'b10});
    chk("lu_resume_cnt", {240'd0, bus.bubble_cnt}, 256'd1);

    // 3: load to $zero never hazards
    id_lw(5'd29, 5'd0);
    step("zero_load");
    set_id(1'b1, 6'b100001, 2'b10, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9,
           32'h5, 32'h6, 32'h0000_4820, 32'h0040_0020);
    step("zero_use");
    chk("zero_stall", {255'd0, last_stall}, 256'd0);
    chk("zero_valid", {255'd0, bus.ex_valid}, 256'd1);
    chk("zero_cnt", {240'd0, bus.bubble_cnt}, 256'd1);

    // 4: flush over a load-use: bubble, no stall, no count
    id_lw(5'd29, 5'd8);
    step("flu_load");
    id_add();
    bus.flush = 1'b1;
    step("flu_flush");
    bus.flush = 1'b0;
    chk("flu_stall", {255'd0, last_stall}, 256'd0);
    chk("flu_valid", {255'd0, bus.ex_valid}, 256'd0);
    chk("flu_cnt", {240'd0, bus.bubble_cnt}, 256'd1);

    // 5: hold freezes an R-type in EX; flush on the second held cycle still bubbles
    set_id(1'b1, 6'b100001, 2'b10, 1'b1, 1'b1, 5'd3, 5'd4, 5'd5,
           32'h1234_5678, 32'h0000_0009, 32'h0000_2820, 32'h0040_0030);
    step("hold_load");
    bus.hold = 1'b1;
    rand_id();
    step("hold_c1");
    chk("hold_c1_stall", {255'd0, last_stall}, 256'd1);
    chk("hold_c1_rd1", {224'd0, bus.ex_rd1}, {224'd0, 32'h1234_5678});
    rand_id();
    bus.flush = 1'b1;
    step("hold_c2");
    bus.flush = 1'b0;
    chk("hold_c2_stall", {255'd0, last_stall}, 256'd1);
    chk("hold_c2_valid", {255'd0, bus.ex_valid}, 256'd0);
    chk("hold_c2_rd1", {224'd0, bus.ex_rd1}, 256'd0);
    rand_id();
    step("hold_c3");
    chk("hold_c3_stall", {255'd0, last_stall}, 256'd1);
    bus.hold = 1'b0;

    // Randomized traffic with occasional reset, hold and flush
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(63) == 0);
      bus.hold  = ($urandom_range(7) == 0);
      bus.flush = ($urandom_range(7) == 0);
      rand_id();
      step("rand");
    end
    rst       = 1'b0;
    bus.hold  = 1'b0;
    bus.flush = 1'b0;

    // 6: saturation; preset the counter near the top, then keep forcing load-use
    force dut.bubble_cnt_p1 = 16'hFFFD;
    #1;
    release dut.bubble_cnt_p1;
    m_cnt = 16'hFFFD;
    id_lw(5'd8, 5'd8);
    for (int i = 0; i < 8; i++) step("sat");
    chk("sat_cnt", {240'd0, bus.bubble_cnt}, {240'd0, 16'hFFFF});
    step("sat_more");
    step("sat_more2");
    chk("sat_hold", {240'd0, bus.bubble_cnt}, {240'd0, 16'hFFFF});

    // Reset asserted while a hold stall is active: stall drops at once, EX clears
    bus.hold = 1'b1;
    step("rstmid_hold");
    rst = 1'b1;
    step("rstmid_rst");
    chk("rstmid_stall", {255'd0, last_stall}, 256'd0);
    chk("rstmid_cnt", {240'd0, bus.bubble_cnt}, 256'd0);
    rst      = 1'b0;
    bus.hold = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage for the 5-stage MIPS core.
- Registers decoded control, operands, immediate and register specifiers from ID into EX.
- Presents ALUop and func directly to the EX-stage ALU control decoder.
- Integrates load-use hazard detection, bubble insertion, branch flush and downstream hold. Drives the stall to PC and IF/ID.

Parameters:
DW, 32, datapath width (operands, immediate, PC+4)
RW, 5, register-specifier width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
id_valid  input  1  ID holds a real instruction
id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst  input  1 each  decoded control
id_alu_op  input  2  ALUop from main controller
id_uses_rs, id_uses_rt  input  1 each  instruction reads rs / rt
id_rd1, id_rd2  input  DW each  register-file read data
id_imm  input  DW  sign-extended immediate
id_pc4  input  DW  PC+4
id_rs, id_rt, id_rd  input  RW each  register specifiers
flush  input  1  branch/jump taken; discard ID instruction
hold  input  1  downstream freeze; EX contents must not change
stall_o  output  1  freeze PC and IF/ID this cycle (combinational)
ex_valid  output  1  EX holds a real instruction
ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst  output  1 each
ex_alu_op  output  2  to ALU control decoder
ex_func  output  6  = ex_imm[5:0], to ALU control decoder
ex_rd1, ex_rd2, ex_imm, ex_pc4  output  DW each
ex_rs, ex_rt, ex_rd  output  RW each
bubble_cnt  output  16  saturating count of load-use bubbles inserted

Behaviour:
- Reset:
  - All registered outputs are 0, including ex_valid, ex_alu_op=2'b00 and bubble_cnt.
  - stall_o is 0 during rst.
- Load-use detection, combinational:
  - lu = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- stall_o = ~rst & (hold | (lu & ~flush)).
- Next-state selection, evaluated at each clk edge, highest priority first:
  1. rst: clear everything.
  2. flush: insert bubble.
  3. hold: keep all EX registers, including ex_valid.
  4. lu: insert bubble and increment bubble_cnt.
  5. otherwise: load all id_* fields, with ex_valid <= id_valid.
- Bubble:
  - ex_valid=0 and all six control bits=0.
  - ex_alu_op=00; data and specifier fields=0.
  - The result is a NOP: no register write and no memory access.
- flush together with hold: flush wins. EX becomes a bubble; stall_o still asserts because of hold.
- flush together with lu: bubble is inserted, bubble_cnt does not increment, stall_o is not asserted by lu.
- Latency: ID values appear on ex_* exactly one cycle after the loading edge.
- Load-use bubble timing:
  - After a load-use bubble, lu is 0 on the next cycle because ex_valid=0.
  - The held ID instruction therefore loads on the following edge, giving exactly one bubble per load-use.
- ex_rt==0 never triggers lu ($zero is never a hazard).
- bubble_cnt saturates at 16'hFFFF and does not wrap.
- Reset asserted mid-stall: the next edge clears EX; stall_o drops in the same cycle rst is asserted.

Test Plan:
1. Reset → hold rst 2 cycles with random id_* inputs → all ex_* =0, ex_valid=0, stall_o=0, bubble_cnt=0.
2. Normal flow → lw $8 in EX (ex_mem_read=1, ex_rt=8) and add $9,$8,$10 in ID (id_rs=8, id_uses_rs=1) → stall_o=1 for one cycle; next cycle ex_valid=0 with all controls 0; the cycle after, the add loads (ex_rs=8, ex_func=6'b100000, ex_alu_op=2'b10); bubble_cnt=1.
3. Load-use on $zero → ex_rt=0, id_rs=0 → stall_o=0, no bubble.
4. Flush over load-use → same setup as 2 plus flush=1 → EX bubble, stall_o=0, bubble_cnt unchanged.
5. hold=1 for 3 cycles while an R-type (id_rd1=32'h1234_5678) sits in EX and ID changes → ex_* frozen at 32'h1234_5678, stall_o=1 throughout; flush asserted on cycle 2 → bubble despite hold.
6. Saturation → force 65 536 load-use bubbles → bubble_cnt=16'hFFFF and stays there on the next bubble.
